reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- Two-read/one-write register file that directly feeds the ALU's read1/read2 operands.
- Read data is registered: operands appear one clock after the addresses, aligned with the clocked ALU stage.
- Register 0 is hardwired to zero.
- Same-cycle write-to-read bypass, so the ALU never sees stale operands after a write.

Parameters:
- DATA_WIDTH, 32, width of each register and of read/write data.
- ADDR_WIDTH, 5, register address width; register count NUM_REGS = 2**ADDR_WIDTH (32).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- read_reg1  input  ADDR_WIDTH  address for operand 1.
- read_reg2  input  ADDR_WIDTH  address for operand 2.
- write_reg  input  ADDR_WIDTH  write address.
- write_data  input  DATA_WIDTH  write data.
- reg_write  input  1  write enable.
- stall  input  1  hold read1/read2 at current values.
- read1  output  DATA_WIDTH  registered operand 1 to ALU read1.
- read2  output  DATA_WIDTH  registered operand 2 to ALU read2.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset, sampled on a clk rising edge:
  - All NUM_REGS registers clear to 0.
  - read1 and read2 clear to 0.
  - reset overrides reg_write and stall in the same cycle; a write presented during reset is discarded.
  - Reset asserted mid-operation (e.g. during a stall) takes effect at the next edge with no residual state.
- Write, at the edge where reg_write=1 and reset=0:
  - regs[write_reg] <= write_data.
  - Writes to address 0 are ignored; regs[0] always reads 0.
- Read, at each edge where reset=0 and stall=0:
  - read1 <= value(read_reg1), read2 <= value(read_reg2).
  - value(a) = 0 if a==0.
  - Otherwise value(a) = write_data if reg_write==1 and write_reg==a (bypass).
  - Otherwise value(a) = regs[a] as held before the edge.
- Latency: address to read data is 1 cycle. Write to visibility is 0 cycles via bypass; the written value appears on read1/read2 at the same edge the write commits.
- Stall, while stall=1:
  - read1 and read2 hold their previous values.
  - Writes still commit to the array.
  - Held outputs are NOT refreshed by a write to the held address. The value becomes visible at the first edge after stall deasserts, provided the address is still presented.
- Simultaneous events:
  - read_reg1 == read_reg2 == write_reg: both outputs receive write_data (if the address is nonzero).
  - Both ports at address 0 always yield 0, regardless of a write to address 0.
- Outputs are driven only from flops; no combinational path from inputs to read1/read2.
- Storage is flops only, no memory macros, so reset can clear every register in one cycle.
- Address width is exact: every ADDR_WIDTH value is a valid register, so no out-of-range case exists.

Optional Feature:
- Macro: REG_FILE_DEBUG_EN.
- Defined: adds input dbg_addr [ADDR_WIDTH-1:0] and output dbg_data [DATA_WIDTH-1:0].
  - dbg_data is a combinational read of regs[dbg_addr], with no bypass; address 0 gives 0.
  - The debug port has no effect on read1/read2 or on writes.
- Undefined: both ports are absent and there is no extra logic.
- Bench checks dbg_data only under the macro.

Test Plan:
- Reset clear: preload regs 1..31 with nonzero values, assert reset for 1 cycle with reg_write=1, write_reg=5, write_data=32'hDEAD. Required: read1=read2=0, all regs 0, reg 5 = 0.
- Basic write then read: write reg 1=32'h1 and reg 2=32'h3 on successive edges, then read_reg1=1, read_reg2=2. Required: read1=1, read2=3 one cycle later, matching ALU operation 4'b0010 stimulus (add gives 4).
- Bypass: in a single cycle, reg_write=1, write_reg=7, write_data=32'hA5A5A5A5, read_reg1=7, read_reg2=7 (reg 7 previously 0). Required: both outputs = 32'hA5A5A5A5 after that edge.
- Register zero: write reg 0 = 32'hFFFFFFFF, read_reg1=0 in the same cycle and the next. Required: read1=0 both cycles.
- Stall hold: read1=32'h11 from reg 3, assert stall 3 cycles while writing reg 3 = 32'h22 and changing read_reg1 to 4. Required: read1 stays 32'h11 through the stall. After stall drops with read_reg1=3, read1=32'h22 after one edge.
- Reset during stall: stall=1 with read2=32'h55, assert reset. Required: read2=0 at the next edge, and stays 0 after stall deasserts while reading an unwritten register.

Source files
------------

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module   : reg_file
// Brief    : 2-read/1-write flop register file with registered, bypassed
//            operands for the ALU; register 0 reads as zero.
//            Optional debug read port enabled by macro REG_FILE_DEBUG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reg_write,
    input  logic                  stall,
`ifdef REG_FILE_DEBUG_EN
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data,
`endif
    output logic [DATA_WIDTH-1:0] read1,
    output logic [DATA_WIDTH-1:0] read2
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] w_val1;
    logic [DATA_WIDTH-1:0] w_val2;
    logic [DATA_WIDTH-1:0] r_read1;
    logic [DATA_WIDTH-1:0] r_read2;

    assign w_regs[0] = '0;

    // One flop bank per register so reset clears the whole array in a cycle.
    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_WIDTH-1:0] r_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_q <= '0;
                end else if (reg_write && (write_reg == ADDR_WIDTH'(gi))) begin
                    r_q <= write_data;
                end
            end
            assign w_regs[gi] = r_q;
        end
    endgenerate

    // Zero check precedes the bypass so a write to register 0 never leaks out.
    always_comb begin
        w_val1 = w_regs[read_reg1];
        if (read_reg1 == '0) begin
            w_val1 = '0;
        end else if (reg_write && (write_reg == read_reg1)) begin
            w_val1 = write_data;
        end
    end

    always_comb begin
        w_val2 = w_regs[read_reg2];
        if (read_reg2 == '0) begin
            w_val2 = '0;
        end else if (reg_write && (write_reg == read_reg2)) begin
            w_val2 = write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_read1 <= '0;
            r_read2 <= '0;
        end else if (!stall) begin
            r_read1 <= w_val1;
            r_read2 <= w_val2;
        end
    end

    assign read1 = r_read1;
    assign read2 = r_read2;

`ifdef REG_FILE_DEBUG_EN
    assign dbg_data = w_regs[dbg_addr];
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file
// Brief    : Self-checking bench for reg_file: directed scenarios followed by
//            randomized traffic against a behavioural array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk;
    logic          reset;
    logic [AW-1:0] read_reg1;
    logic [AW-1:0] read_reg2;
    logic [AW-1:0] write_reg;
    logic [DW-1:0] write_data;
    logic          reg_write;
    logic          stall;
    logic [DW-1:0] read1;
    logic [DW-1:0] read2;
`ifdef REG_FILE_DEBUG_EN
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;
`endif

    reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .reg_write  (reg_write),
        .stall      (stall),
`ifdef REG_FILE_DEBUG_EN
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
`endif
        .read1      (read1),
        .read2      (read2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: architectural register contents and expected outputs.
    logic [DW-1:0] mdl [NR];
    logic [DW-1:0] exp1;
    logic [DW-1:0] exp2;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] operand(input int a);
        if (a == 0) return '0;
        if (reg_write && (int'(write_reg) == a)) return write_data;
        return mdl[a];
    endfunction

    task automatic set_in(input logic r, input logic s, input logic w, input int wa,
                          input logic [DW-1:0] wd, input int a1, input int a2);
        reset      = r;
        stall      = s;
        reg_write  = w;
        write_reg  = AW'(wa);
        write_data = wd;
        read_reg1  = AW'(a1);
        read_reg2  = AW'(a2);
    endtask

    // Advance one clock, update the model from the pre-edge inputs, compare.
    task automatic step();
        logic [DW-1:0] n1, n2;
        n1 = exp1;
        n2 = exp2;
        if (reset) begin
            n1 = '0;
            n2 = '0;
        end else if (!stall) begin
            n1 = operand(int'(read_reg1));
            n2 = operand(int'(read_reg2));
        end
        @(posedge clk);
        #1;
        if (reset) begin
            for (int i = 0; i < NR; i++) mdl[i] = '0;
        end else if (reg_write && (write_reg != '0)) begin
            mdl[write_reg] = write_data;
        end
        exp1 = n1;
        exp2 = n2;
        check("model_read1", read1, exp1);
        check("model_read2", read2, exp2);
`ifdef REG_FILE_DEBUG_EN
        check("model_dbg", dbg_data, mdl[dbg_addr]);
`endif
    endtask

    initial begin
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        exp1 = '0;
        exp2 = '0;
`ifdef REG_FILE_DEBUG_EN
        dbg_addr = '0;
`endif
        set_in(1'b1, 1'b0, 1'b0, 0, '0, 0, 0);
        @(negedge clk);
        step();
        step();
        check("reset_read1", read1, 32'h0);
        check("reset_read2", read2, 32'h0);

        // Preload, then reset with a concurrent write that must be discarded.
        for (int i = 1; i < NR; i++) begin
            set_in(1'b0, 1'b0, 1'b1, i, DW'(i) * 32'h0101_0101 + 32'h10, i, NR - i);
            step();
        end
        check("preload_r1", read1, 32'h1F1F_1F2F);
        set_in(1'b1, 1'b0, 1'b1, 5, 32'hDEAD, 5, 5);
        step();
        check("rst_wr_read1", read1, 32'h0);
        check("rst_wr_read2", read2, 32'h0);
        for (int i = 0; i < NR; i++) begin
            set_in(1'b0, 1'b0, 1'b0, 0, '0, i, i);
            step();
            check("cleared_reg", read1, 32'h0);
        end
        set_in(1'b0, 1'b0, 1'b0, 0, '0, 5, 5);
        step();
        check("cleared_reg5", read2, 32'h0);

        // Basic write then read; operands sum to 4 at the ALU.
        set_in(1'b0, 1'b0, 1'b1, 1, 32'h1, 0, 0);
        step();
        set_in(1'b0, 1'b0, 1'b1, 2, 32'h3, 0, 0);
        step();
        set_in(1'b0, 1'b0, 1'b0, 0, '0, 1, 2);
        step();
        check("basic_read1", read1, 32'h1);
        check("basic_read2", read2, 32'h3);
        check("basic_add", read1 + read2, 32'h4);

        // Same-edge bypass to both ports.
        set_in(1'b0, 1'b0, 1'b1, 7, 32'hA5A5_A5A5, 7, 7);
        step();
        check("bypass_read1", read1, 32'hA5A5_A5A5);
        check("bypass_read2", read2, 32'hA5A5_A5A5);

        // Register zero ignores writes and its bypass.
        set_in(1'b0, 1'b0, 1'b1, 0, 32'hFFFF_FFFF, 0, 0);
        step();
        check("zero_same", read1, 32'h0);
        set_in(1'b0, 1'b0, 1'b0, 0, '0, 0, 0);
        step();
        check("zero_next", read1, 32'h0);

        // Stall holds outputs while the write still commits.
        set_in(1'b0, 1'b0, 1'b1, 3, 32'h11, 3, 0);
        step();
        set_in(1'b0, 1'b0, 1'b0, 0, '0, 3, 0);
        step();
        check("stall_pre", read1, 32'h11);
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b1, 1'b1, 3, 32'h22, 4, 0);
            step();
            check("stall_hold", read1, 32'h11);
        end
        set_in(1'b0, 1'b0, 1'b0, 0, '0, 3, 0);
        step();
        check("stall_release", read1, 32'h22);

        // Reset during stall clears held outputs.
        set_in(1'b0, 1'b0, 1'b1, 6, 32'h55, 0, 6);
        step();
        check("rs_pre", read2, 32'h55);
        set_in(1'b1, 1'b1, 1'b0, 0, '0, 0, 6);
        step();
        check("rs_reset", read2, 32'h0);
        set_in(1'b0, 1'b1, 1'b0, 0, '0, 0, 9);
        step();
        check("rs_stall", read2, 32'h0);
        set_in(1'b0, 1'b0, 1'b0, 0, '0, 0, 9);
        step();
        check("rs_after", read2, 32'h0);

        // Randomized traffic, biased toward address collisions.
        for (int n = 0; n < 600; n++) begin
            int wa, a1, a2;
            wa = int'($urandom_range(NR - 1));
            a1 = ($urandom_range(3) == 0) ? wa : int'($urandom_range(NR - 1));
            a2 = ($urandom_range(3) == 0) ? wa : int'($urandom_range(NR - 1));
            set_in($urandom_range(49) == 0, $urandom_range(3) == 0, $urandom_range(1) == 1,
                   wa, DW'($urandom), a1, a2);
`ifdef REG_FILE_DEBUG_EN
            dbg_addr = AW'($urandom_range(NR - 1));
`endif
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
